// File: rtl/fixed_mul.sv
// fixed_mul: sequential signed fixed-point multiplier (default Q24.8).
// Sign-magnitude shift-add over WIDTH-1 magnitude bits, then round-half-to-even
// down to FBITS fractional bits, overflow detection and sign restoration.
module fixed_mul #(
  parameter int WIDTH = 32,
  parameter int FBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             ovf,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] val
);

  localparam int MW = WIDTH - 1;        // magnitude width
  localparam int PW = 2 * MW;           // full-precision product width
  localparam int CW = $clog2(WIDTH);    // iteration counter width
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 2);
  localparam logic [WIDTH-1:0] SMALLEST  = {1'b1, {MW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CALC  = 3'd2,
    ROUND = 3'd3,
    SIGN  = 3'd4
  } state_t;

  state_t           state_q;
  logic [MW-1:0]    a_mag_q;
  logic [MW-1:0]    b_mag_q;
  logic             sign_diff_q;
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic [MW-1:0]    q_q;
  logic             busy_q;
  logic             done_q;
  logic             valid_q;
  logic             ovf_q;
  logic [WIDTH-1:0] val_q;

  // Magnitudes of the incoming operands; SMALLEST is rejected before these are used.
  logic [MW-1:0] a_mag_d;
  logic [MW-1:0] b_mag_d;
  assign a_mag_d = a[WIDTH-1] ? MW'(-a) : a[MW-1:0];
  assign b_mag_d = b[WIDTH-1] ? MW'(-b) : b[MW-1:0];

  // One shift-add step: add |a| << i when bit i of |b| is set.
  logic [PW-1:0] partial_d;
  logic [PW-1:0] acc_d;
  assign partial_d = {{MW{1'b0}}, a_mag_q} << cnt_q;
  assign acc_d     = b_mag_q[cnt_q] ? acc_q + partial_d : acc_q;

  // Guard and sticky bits; with FBITS < 2 the missing bits count as zero.
  logic guard;
  logic sticky;
  generate
    if (FBITS == 0) begin : g_no_frac
      assign guard  = 1'b0;
      assign sticky = 1'b0;
    end else if (FBITS == 1) begin : g_one_frac
      assign guard  = acc_q[0];
      assign sticky = 1'b0;
    end else begin : g_frac
      assign guard  = acc_q[FBITS-1];
      assign sticky = |acc_q[FBITS-2:0];
    end
  endgenerate

  // Round-half-to-even of the rescaled product and its overflow flag.
  logic [PW:0] q_trunc_d;
  logic [PW:0] q_rnd_d;
  logic        round_up_d;
  logic        ovf_rnd_d;
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    q_trunc_d  = '0;
    round_up_d = 1'b0;
    q_rnd_d    = '0;
    ovf_rnd_d  = 1'b0;
    q_trunc_d  = {1'b0, acc_q >> FBITS};
    round_up_d = guard & (sticky | acc_q[FBITS]);
    q_rnd_d    = q_trunc_d + {{PW{1'b0}}, round_up_d};
    ovf_rnd_d  = |q_rnd_d[PW:MW];
  end

  // Signed result; a zero magnitude is never negated.
  logic [WIDTH-1:0] q_ext;
  logic [WIDTH-1:0] val_d;
  assign q_ext = {1'b0, q_q};
  assign val_d = (sign_diff_q && (q_q != '0)) ? -q_ext : q_ext;

  // Control FSM with registered status outputs and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset too so outputs and state are fully
      // defined the instant reset asserts, independent of clock activity.
      state_q     <= IDLE;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      sign_diff_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      val_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if ((a == SMALLEST) || (b == SMALLEST)) begin
              ovf_q   <= 1'b1;
              done_q  <= 1'b1;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              a_mag_q     <= a_mag_d;
              b_mag_q     <= b_mag_d;
              sign_diff_q <= a[WIDTH-1] ^ b[WIDTH-1];
              busy_q      <= 1'b1;
              valid_q     <= 1'b0;
              ovf_q       <= 1'b0;
              state_q     <= INIT;
            end
          end
        end
        INIT: begin
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (ovf_rnd_d) begin
            ovf_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            q_q     <= q_rnd_d[MW-1:0];
            state_q <= SIGN;
          end
        end
        SIGN: begin
          val_q   <= val_d;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign val   = val_q;

endmodule

// File: tb/tb_fixed_mul.sv
// tb_fixed_mul: directed-vector bench for fixed_mul in its default Q24.8 format.
// Edge counts include the accepting edge as edge 1, so a normal result raises
// done on edge WIDTH+3 and an overflow found in ROUND raises it on edge WIDTH+2.
module tb_fixed_mul;

  localparam int WIDTH = 32;
  localparam int FBITS = 8;
  localparam int LAT   = WIDTH + 3;
  localparam int TMO   = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        valid;
  logic        ovf;
  logic [31:0] val;

  int checks   = 0;
  int failures = 0;

  fixed_mul #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .busy (busy),
    .done (done),
    .valid(valid),
    .ovf  (ovf),
    .a    (a),
    .b    (b),
    .val  (val)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble the operands after acceptance, wait for done.
  task automatic do_mul(input logic [31:0] ai, input logic [31:0] bi,
                        output logic [31:0] o_val, output logic o_valid,
                        output logic o_ovf, output int o_edges);
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ai; b = bi ^ 32'h5A5A5A5A;
    o_edges = 1;
    while (done !== 1'b1 && o_edges < TMO) begin
      @(posedge clk); #1;
      o_edges++;
    end
    o_val = val; o_valid = valid; o_ovf = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, valid, ovf} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, valid, ovf});
    end
    checks++;
    if (val !== 32'h0) begin
      failures++;
      $display("FAIL reset_val: got %h expected 00000000", val);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Legal, non-overflowing products; also used for the rounding vectors.
  task automatic run_vectors(input string tag, input logic [31:0] va[],
                             input logic [31:0] vb[], input logic [31:0] vexp[]);
    logic [31:0] r_val;
    logic        r_valid;
    logic        r_ovf;
    int          r_edges;
    for (int i = 0; i < va.size(); i++) begin
      do_mul(va[i], vb[i], r_val, r_valid, r_ovf, r_edges);
      checks++;
      if (r_edges !== LAT) begin
        failures++;
        $display("FAIL %s[%0d]_latency: got %0d expected %0d", tag, i, r_edges, LAT);
      end
      checks++;
      if (r_val !== vexp[i]) begin
        failures++;
        $display("FAIL %s[%0d]_val: got %h expected %h", tag, i, r_val, vexp[i]);
      end
      checks++;
      if ({r_valid, r_ovf} !== 2'b10) begin
        failures++;
        $display("FAIL %s[%0d]_valid_ovf: got %b expected 10", tag, i, {r_valid, r_ovf});
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] va[]   = '{32'h00000180, 32'hFFFFFE80, 32'h00000000, 32'hFFFFFF00,
                            32'h7FFFFFFF, 32'h80000001};
    logic [31:0] vb[]   = '{32'h00000200, 32'h00000200, 32'hFFFFFF00, 32'hFFFFFE00,
                            32'h00000100, 32'h00000100};
    logic [31:0] vexp[] = '{32'h00000300, 32'hFFFFFD00, 32'h00000000, 32'h00000200,
                            32'h7FFFFFFF, 32'h80000001};
    run_vectors("basic", va, vb, vexp);
  endtask

  task automatic test_rounding();
    // 1*0x80: tie, even -> 0; 3*0x80: tie, odd -> 2; 1*0x81: above half -> 1;
    // -1/256 * 1/256 -> 0 (not negative); -3*0x80 -> -2.
    logic [31:0] va[]   = '{32'h00000001, 32'h00000003, 32'h00000001, 32'hFFFFFFFF,
                            32'hFFFFFFFD};
    logic [31:0] vb[]   = '{32'h00000080, 32'h00000080, 32'h00000081, 32'h00000001,
                            32'h00000080};
    logic [31:0] vexp[] = '{32'h00000000, 32'h00000002, 32'h00000001, 32'h00000000,
                            32'hFFFFFFFE};
    run_vectors("round", va, vb, vexp);
  endtask

  task automatic test_overflow();
    logic [31:0] va[] = '{32'h7FFF0000, 32'h00010000, 32'hFFFF0000};
    logic [31:0] vb[] = '{32'h00000200, 32'h00800000, 32'h00800000};
    logic [31:0] r_val;
    logic        r_valid;
    logic        r_ovf;
    int          r_edges;
    do_mul(32'h00000180, 32'h00000200, r_val, r_valid, r_ovf, r_edges);
    for (int i = 0; i < 3; i++) begin
      do_mul(va[i], vb[i], r_val, r_valid, r_ovf, r_edges);
      checks++;
      if (r_edges !== LAT - 1) begin
        failures++;
        $display("FAIL ovf[%0d]_latency: got %0d expected %0d", i, r_edges, LAT - 1);
      end
      checks++;
      if ({r_valid, r_ovf, busy} !== 3'b010) begin
        failures++;
        $display("FAIL ovf[%0d]_flags: got %b expected 010", i, {r_valid, r_ovf, busy});
      end
      checks++;
      if (r_val !== 32'h00000300) begin
        failures++;
        $display("FAIL ovf[%0d]_val_held: got %h expected 00000300", i, r_val);
      end
    end
  endtask

  task automatic test_smallest();
    logic [31:0] va[] = '{32'h80000000, 32'h00000100};
    logic [31:0] vb[] = '{32'h00000100, 32'h80000000};
    logic [31:0] r_val;
    logic        r_valid;
    logic        r_ovf;
    int          r_edges;
    for (int i = 0; i < 2; i++) begin
      do_mul(va[i], vb[i], r_val, r_valid, r_ovf, r_edges);
      checks++;
      if (r_edges !== 1) begin
        failures++;
        $display("FAIL smallest[%0d]_latency: got %0d expected 1", i, r_edges);
      end
      checks++;
      if ({r_valid, r_ovf, busy} !== 3'b010) begin
        failures++;
        $display("FAIL smallest[%0d]_flags: got %b expected 010", i, {r_valid, r_ovf, busy});
      end
      @(posedge clk); #1;
      checks++;
      if ({done, busy} !== 2'b00) begin
        failures++;
        $display("FAIL smallest[%0d]_after: got done,busy=%b expected 00", i, {done, busy});
      end
    end
  endtask

  task automatic test_busy_ignore();
    int edges;
    @(negedge clk);
    a = 32'h00000180; b = 32'h00000200; start = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    checks++;
    if ({busy, valid, ovf} !== 3'b100) begin
      failures++;
      $display("FAIL busy_accept_flags: got %b expected 100", {busy, valid, ovf});
    end
    a = 32'h7FFF0000; b = 32'h7FFF0000;
    repeat (5) begin
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    while (done !== 1'b1 && edges < TMO) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges !== LAT) begin
      failures++;
      $display("FAIL busy_latency: got %0d expected %0d", edges, LAT);
    end
    checks++;
    if ({val, valid, ovf} !== {32'h00000300, 2'b10}) begin
      failures++;
      $display("FAIL busy_result: got val=%h valid=%b ovf=%b expected val=00000300 valid=1 ovf=0",
               val, valid, ovf);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = 32'hFFFFFE80; b = 32'h00000200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (LAT - 2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_early_done: got %b expected 0", done);
    end
    start = 1'b1; a = 32'h00000180; b = 32'h00000200;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({done, busy, valid, val} !== {3'b101, 32'hFFFFFD00}) begin
      failures++;
      $display("FAIL b2b_done: got done=%b busy=%b valid=%b val=%h expected 1 0 1 fffffd00",
               done, busy, valid, val);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({done, busy, valid, val} !== {3'b001, 32'hFFFFFD00}) begin
        failures++;
        $display("FAIL b2b_hold[%0d]: got done=%b busy=%b valid=%b val=%h expected 0 0 1 fffffd00",
                 i, done, busy, valid, val);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r_val;
    logic        r_valid;
    logic        r_ovf;
    int          r_edges;
    bit          saw_done;
    @(negedge clk);
    a = 32'h00000180; b = 32'h00000200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Edge 2 is INIT; CALC iteration 10 runs on edge 13.
    repeat (12) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy_before: got %b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, valid, ovf, val} !== {4'b0000, 32'h0}) begin
      failures++;
      $display("FAIL mid_async_reset: got flags=%b val=%h expected 0000 00000000",
               {busy, done, valid, ovf}, val);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_aborted: got activity=%b expected 0", saw_done);
    end
    do_mul(32'h00000180, 32'h00000200, r_val, r_valid, r_ovf, r_edges);
    checks++;
    if ({r_edges, r_val, r_valid, r_ovf} !== {LAT, 32'h00000300, 2'b10}) begin
      failures++;
      $display("FAIL mid_restart: got edges=%0d val=%h valid=%b ovf=%b expected %0d 00000300 1 0",
               r_edges, r_val, r_valid, r_ovf, LAT);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_smallest();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_mul.md
FIXED_MUL -- requirements
Module: fixed_mul

Interface
REQ-001 Parameter WIDTH, default 32, total operand/result width in bits (signed, two's complement).
REQ-002 Parameter FBITS, default 8, fractional bits within WIDTH (default format is signed 24.8).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request a multiply; SHALL be honoured only in IDLE.
REQ-006 busy  output  1  calculation in progress.
REQ-007 done  output  1  single-cycle pulse at the end of every accepted request, including overflow exits.
REQ-008 valid  output  1  val holds a correct result.
REQ-009 ovf  output  1  result not representable in WIDTH bits.
REQ-010 a  input  WIDTH  signed multiplicand, sampled on the accepting edge only.
REQ-011 b  input  WIDTH  signed multiplier, sampled on the accepting edge only.
REQ-012 val  output  WIDTH  signed product a*b, rescaled to FBITS fractional bits.

Function
REQ-013 States SHALL be IDLE, INIT, CALC, ROUND and SIGN.
REQ-014 IDLE with start=1, with a or b equal to SMALLEST (1 followed by WIDTH-1 zeros), SHALL leave the state at IDLE and set ovf=1, done=1, valid=0 and busy=0 on that edge.
REQ-015 IDLE with start=1 and otherwise legal operands SHALL do all of the following on that edge:
- register |a| and |b| as WIDTH-1-bit unsigned values;
- register sign_diff = a[WIDTH-1] ^ b[WIDTH-1];
- set busy=1, valid=0 and ovf=0;
- go to INIT.
REQ-016 INIT SHALL clear the 2*(WIDTH-1)-bit product accumulator and the iteration counter, then go to CALC.
REQ-017 CALC SHALL run exactly WIDTH-1 iterations, one per cycle:
- shift-add LSB-first over the |b| bits;
- add |a| shifted by i into the accumulator when |b|[i]=1;
- after iteration WIDTH-2, go to ROUND.
REQ-018 ROUND SHALL compute q = P >> FBITS with round-half-to-even, using guard = P[FBITS-1], sticky = OR of P[FBITS-2:0] and lsb = P[FBITS].
REQ-019 ROUND SHALL increment q when guard=1 and (sticky=1 or lsb=1).
REQ-020 If the rounded q is at least 2^(WIDTH-1), ROUND SHALL set ovf=1, done=1, busy=0 and valid=0, go to IDLE, and leave val unchanged.
REQ-021 If the rounded q is below 2^(WIDTH-1), ROUND SHALL go to SIGN.
REQ-022 SIGN SHALL set val = -q when sign_diff=1 and q!=0, otherwise val = q, so a zero result is never negative.
REQ-023 SIGN SHALL set done=1, valid=1 and busy=0, then go to IDLE.
REQ-024 Latency for legal, non-overflowing operands SHALL be WIDTH+3 edges from the accepting edge to the edge that raises done (35 edges at WIDTH=32).
REQ-025 done SHALL default to 0 on every edge unless set by REQ-014, REQ-020 or REQ-023.
REQ-026 start while busy=1 SHALL be ignored: no restart, and operands are not resampled.
REQ-027 Changes on a or b after the accepting edge SHALL NOT affect the result.
REQ-028 valid and val SHALL hold their values until the next accepted start or reset.
REQ-029 start asserted in the same cycle as done SHALL be ignored, because the state is not IDLE yet.
REQ-030 FBITS=0 SHALL be legal: guard and sticky are treated as 0, so no rounding occurs.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for clk, force state=IDLE and busy=0, done=0, valid=0, ovf=0, val=0.
REQ-032 rst asserted mid-calculation SHALL abort the request, with no done pulse for it.
REQ-033 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-034 a=0x00000180 (1.5), b=0x00000200 (2.0), start -> done 35 edges later, val=0x00000300, valid=1, ovf=0.
REQ-035 a=0xFFFFFE80 (-1.5), b=0x00000200 -> val=0xFFFFFD00; a=0 and b=0xFFFFFF00 -> val=0x00000000.
REQ-036 Rounding, a=0x00000001 and b=0x00000080 -> val=0x00000000 (tie rounds to even).
REQ-037 Rounding, a=0x00000003 and b=0x00000080 -> val=0x00000002 (tie with odd lsb rounds up).
REQ-038 a=0x7FFF0000, b=0x00000200 -> ovf=1, valid=0, done pulse.
REQ-039 a=0x80000000 -> ovf=1 and done on the accepting edge, busy never set.
REQ-040 rst pulsed at CALC iteration 10 -> all outputs 0 asynchronously and no done.
REQ-041 After the REQ-040 reset, a new 1.5*2.0 request -> val=0x00000300.
